// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
// ORDER-stage cascaded integrator-comb decimator turning a 1-bit PDM stream
// into signed OUT_BW-bit PCM at 1/DECIM of the input sample rate.
// PDM bits map bipolar (1 -> +1, 0 -> -1). The comb output is arithmetically
// shifted right by SHIFT, then clipped to the OUT_BW range. The first DROP
// decimated results after reset or enable are suppressed while the combs warm up.
//
// Ports
//   clk_i    system clock
//   rst_i    asynchronous, active-high reset
//   en_i     block enable; low synchronously clears all state
//   data_i   PDM bit
//   valid_i  data_i qualifier (a sample is accepted on en_i & valid_i)
//   data_o   signed PCM sample, held between strobes
//   valid_o  single-cycle strobe qualifying data_o
//   sat_o    single-cycle strobe with valid_o when data_o was clipped
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
  parameter int ORDER  = 2,
  parameter int DECIM  = 250,
  parameter int OUT_BW = 8,
  parameter int SHIFT  = 9,
  parameter int DROP   = 2,
  parameter int ACC_BW = ORDER * $clog2(DECIM) + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              data_i,
  input  logic              valid_i,
  output logic [OUT_BW-1:0] data_o,
  output logic              valid_o,
  output logic              sat_o
);

  localparam int CNT_W  = $clog2(DECIM);
  localparam int DROP_W = 4;
  localparam int EXT_W  = ((ACC_BW > OUT_BW) ? ACC_BW : OUT_BW) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(DROP);
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'sd1 <<< (OUT_BW - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_BW-1:0] integ_q [ORDER];
  logic signed [ACC_BW-1:0] integ_d [ORDER];
  logic signed [ACC_BW-1:0] dly_q   [ORDER];
  logic signed [ACC_BW-1:0] comb_in [ORDER];
  logic signed [ACC_BW-1:0] comb_out;
  logic signed [ACC_BW-1:0] snap_q;
  logic signed [ACC_BW-1:0] x;
  logic signed [ACC_BW-1:0] scaled;
  logic signed [EXT_W-1:0]  scaled_ext;
  logic [CNT_W-1:0]         cnt_q;
  logic [DROP_W-1:0]        drop_q;
  logic                     snap_vld_q;
  logic                     accept;
  logic                     tick;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [OUT_BW-1:0]        clipped;

  assign accept = en_i & valid_i;
  assign tick   = accept && (cnt_q == CNT_LAST);
  assign x      = data_i ? ACC_BW'(1) : '1;

  // All integrators advance together; stage k sees the pre-update value of k-1.
  always_comb begin
    integ_d[0] = integ_q[0] + x;
    for (int unsigned k = 1; k < ORDER; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // Comb chain evaluated from the registered snapshot; a running accumulator
  // keeps the chain free of self-referencing array elements.
  always_comb begin
    logic signed [ACC_BW-1:0] acc;
    acc = snap_q;
    for (int unsigned k = 0; k < ORDER; k++) begin
      comb_in[k] = acc;
      acc        = acc - dly_q[k];
    end
    comb_out = acc;
  end

  always_comb begin
    scaled     = comb_out >>> SHIFT;
    scaled_ext = EXT_W'(scaled);
    sat_hi     = scaled_ext > OUT_MAX;
    sat_lo     = scaled_ext < OUT_MIN;
    if (sat_hi) begin
      clipped = OUT_MAX[OUT_BW-1:0];
    end else if (sat_lo) begin
      clipped = OUT_MIN[OUT_BW-1:0];
    end else begin
      clipped = scaled_ext[OUT_BW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      integ_q    <= '{default: '0};
      dly_q      <= '{default: '0};
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      cnt_q      <= '0;
      drop_q     <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      sat_o      <= 1'b0;
    end else if (!en_i) begin
      integ_q    <= '{default: '0};
      dly_q      <= '{default: '0};
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      cnt_q      <= '0;
      drop_q     <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      if (accept) begin
        integ_q <= integ_d;
        cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      end
      snap_vld_q <= tick;
      if (tick) begin
        snap_q <= integ_d[ORDER-1];
      end
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
      if (snap_vld_q) begin
        for (int unsigned k = 0; k < ORDER; k++) begin
          dly_q[k] <= comb_in[k];
        end
        // Warm-up results still advance the comb delays; only the output is withheld.
        if (drop_q != DROP_MAX) begin
          drop_q <= drop_q + 1'b1;
        end else begin
          data_o  <= clipped;
          valid_o <= 1'b1;
          sat_o   <= sat_hi | sat_lo;
        end
      end
    end
  end

endmodule
